stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
Single-clock replacement for the free-running phase clock generator. It produces one-hot stage enables for FE, DC, EX and WB, which the pipeline stages use as clock enables on the main clock. Adds run/halt control, single-step, stall and an instruction-retire counter. Sits at the top of the cpu and drives all four stages.

Parameters:
CNT_W, 32, width of instr_count and cycle_count.
AUTO_RUN, 1, 1 = state after reset is RUN; 0 = state after reset is HALTED.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
run  input  1  pulse; start continuous execution from HALTED.
step  input  1  pulse; execute exactly one instruction (4 phases) from HALTED.
halt_req  input  1  pulse; stop after the current instruction retires.
stall  input  1  level; freeze the sequencer this cycle.
en_fe  output  1  fetch-stage enable (phase 0).
en_dc  output  1  decode-stage enable (phase 1).
en_ex  output  1  execute-stage enable (phase 2).
en_wb  output  1  writeback-stage enable (phase 3).
phase  output  2  current phase register.
halted  output  1  1 when state == HALTED.
instr_count  output  CNT_W  number of retired instructions (WB enables).
cycle_count  output  CNT_W  active-cycle counter (see Optional Feature).

Behaviour:
- States: HALTED, RUN, STEP. Registers: state, phase[1:0], halt_pending, instr_count, cycle_count.
- Reset (rst=1 at edge):
  - phase=0, halt_pending=0, counters=0.
  - state=RUN if AUTO_RUN else HALTED.
  - Reset overrides everything, including reset in the middle of an instruction; the partial instruction is discarded and not counted.
- Enables are combinational:
  - active = (state!=HALTED) & ~stall.
  - en_fe = active & phase==0; en_dc = active & phase==1; en_ex = active & phase==2; en_wb = active & phase==3.
  - At most one enable is high in any cycle.
- Advance: on an edge with active=1, phase <= phase+1 mod 4. With stall=1, phase and state hold and all enables are 0.
- Retire: on an edge with en_wb=1:
  - instr_count <= instr_count+1, wrapping at 2^CNT_W.
  - If state==STEP, or halt_pending, or halt_req is high in the same cycle: state <= HALTED, halt_pending <= 0.
  - phase always wraps to 0, so HALTED always has phase 0.
- halt_req:
  - In RUN or STEP, sets halt_pending. The current instruction completes through WB; no FE follows.
  - Ignored in HALTED.
  - halt_req during stall is still latched.
- HALTED:
  - run -> RUN; step -> STEP.
  - run and step in the same cycle: run wins.
  - First enable (en_fe) is asserted the cycle after the pulse.
- run and step are ignored outside HALTED.
- stall in HALTED has no effect.
- Latency:
  - A non-stalled instruction takes exactly 4 cycles (FE through WB).
  - HALTED->RUN takes 1 cycle.
  - From halt_req in phase p, the sequencer reaches HALTED after 4-p more cycles.

Optional Feature:
Macro STAGE_SEQ_CYCLE_COUNT_EN.
- Defined: cycle_count increments on every edge where state!=HALTED, including stalled cycles. It wraps at 2^CNT_W and resets to 0.
- Undefined: the cycle counter register is not built and cycle_count is tied to 0.

Test Plan:
- AUTO_RUN=0, reset -> halted=1, phase=0, all en_* =0, instr_count=0. Pulse run -> en_fe, en_dc, en_ex, en_wb on the next 4 cycles, then en_fe again; instr_count=1 after the first en_wb.
- RUN; hold stall high 2 cycles while phase==2 -> en_ex=0 for 2 cycles and phase stays 2. Stall low -> en_ex=1, then en_wb=1.
- HALTED; pulse step -> exactly 4 enables (fe, dc, ex, wb), instr_count increments by 1, halted=1 on the following cycle. Pulse run and step together -> continuous RUN.
- RUN; pulse halt_req while phase==1 -> en_ex and en_wb still fire, then halted=1, phase=0, no en_fe. halt_req in the same cycle as en_wb -> halts after that WB.
- RUN mid-instruction (phase 2); assert rst -> next cycle phase=0 and counters=0. With AUTO_RUN=1, en_fe=1 immediately after rst drops.
- With STAGE_SEQ_CYCLE_COUNT_EN: run 10 cycles including 3 stalled cycles -> cycle_count=10, instr_count=1. Without the macro -> cycle_count=0.

Source files
------------

// File: rtl/stage_sequencer_if.sv
// stage_sequencer_if: control and status bundle between a pipeline controller and the stage sequencer
// master: drives run/step/halt_req/stall, observes enables, phase, halted and counters
// slave : the sequencer side of the same signals
interface stage_sequencer_if #(parameter int CNT_W = 32);
   logic             run;
   logic             step;
   logic             halt_req;
   logic             stall;
   logic             en_fe;
   logic             en_dc;
   logic             en_ex;
   logic             en_wb;
   logic [1:0]       phase;
   logic             halted;
   logic [CNT_W-1:0] instr_count;
   logic [CNT_W-1:0] cycle_count;
   modport master (
      output run, step, halt_req, stall,
      input  en_fe, en_dc, en_ex, en_wb, phase, halted, instr_count, cycle_count
   );
   modport slave (
      input  run, step, halt_req, stall,
      output en_fe, en_dc, en_ex, en_wb, phase, halted, instr_count, cycle_count
   );
endinterface

// File: rtl/stage_sequencer.sv
// stage_sequencer: one-hot FE/DC/EX/WB stage enables with run/halt, single-step, stall and retire counting
// clk, rst : clock and synchronous active-high reset
// bus      : slave side of stage_sequencer_if (run/step/halt_req/stall in; enables, phase, halted, counters out)
// STAGE_SEQ_CYCLE_COUNT_EN: when defined, builds the active-cycle counter; otherwise cycle_count is 0
module stage_sequencer #(
   parameter int CNT_W    = 32,
   parameter int AUTO_RUN = 1
) (
   input logic              clk,
   input logic              rst,
   stage_sequencer_if.slave bus
);
   typedef enum logic [1:0] {HALTED, RUN, STEP} state_t;
   state_t           state_q, state_d;
   logic [1:0]       phase_q, phase_d;
   logic             hp_q, hp_d;
   logic [CNT_W-1:0] icnt_q, icnt_d;
   logic             active;
   always_comb begin
      active  = (state_q != HALTED) && !bus.stall;
      state_d = state_q;
      phase_d = phase_q;
      hp_d    = hp_q;
      icnt_d  = icnt_q;
      if (state_q == HALTED) begin
         state_d = bus.run ? RUN : bus.step ? STEP : HALTED;
      end else begin
         if (bus.halt_req) hp_d = 1'b1;
         if (active) phase_d = phase_q + 2'd1;
         // retire: the WB enable ends the instruction and is the only exit to HALTED
         if (active && phase_q == 2'd3) begin
            icnt_d = icnt_q + CNT_W'(1);
            if (state_q == STEP || hp_q || bus.halt_req) begin
               state_d = HALTED;
               hp_d    = 1'b0;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= (AUTO_RUN != 0) ? RUN : HALTED;
         phase_q <= 2'd0;
         hp_q    <= 1'b0;
         icnt_q  <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         hp_q    <= hp_d;
         icnt_q  <= icnt_d;
      end
   end
`ifdef STAGE_SEQ_CYCLE_COUNT_EN
   logic [CNT_W-1:0] ccnt_q;
   // counts every non-halted edge, stalled ones included
   always_ff @(posedge clk) begin
      if (rst) ccnt_q <= '0;
      else if (state_q != HALTED) ccnt_q <= ccnt_q + CNT_W'(1);
   end
   assign bus.cycle_count = ccnt_q;
`else
   assign bus.cycle_count = '0;
`endif
   assign bus.en_fe       = active && phase_q == 2'd0;
   assign bus.en_dc       = active && phase_q == 2'd1;
   assign bus.en_ex       = active && phase_q == 2'd2;
   assign bus.en_wb       = active && phase_q == 2'd3;
   assign bus.phase       = phase_q;
   assign bus.halted      = state_q == HALTED;
   assign bus.instr_count = icnt_q;
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed checks of the stage sequencer (AUTO_RUN=0 main instance, AUTO_RUN=1 reset instance)
module tb_stage_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   ntest = 0;
   int   nfail = 0;
   always #5 clk = ~clk;
   stage_sequencer_if #(.CNT_W(32)) bus ();
   stage_sequencer_if #(.CNT_W(32)) bus_ar ();
   stage_sequencer #(.CNT_W(32), .AUTO_RUN(0)) dut (.clk(clk), .rst(rst), .bus(bus));
   stage_sequencer #(.CNT_W(32), .AUTO_RUN(1)) dut_ar (.clk(clk), .rst(rst), .bus(bus_ar));
   logic [3:0] en, en_ar;
   assign en    = {bus.en_fe, bus.en_dc, bus.en_ex, bus.en_wb};
   assign en_ar = {bus_ar.en_fe, bus_ar.en_dc, bus_ar.en_ex, bus_ar.en_wb};
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      #1;
      ntest++; if (bus.halted !== 1'b1) begin nfail++; $display("FAIL reset_halted got %b exp 1", bus.halted); end
      ntest++; if (bus.phase !== 2'd0) begin nfail++; $display("FAIL reset_phase got %0d exp 0", bus.phase); end
      ntest++; if (en !== 4'b0000) begin nfail++; $display("FAIL reset_en got %b exp 0000", en); end
      ntest++; if (bus.instr_count !== 32'd0) begin nfail++; $display("FAIL reset_icnt got %0d exp 0", bus.instr_count); end
      ntest++; if (bus.cycle_count !== 32'd0) begin nfail++; $display("FAIL reset_ccnt got %0d exp 0", bus.cycle_count); end
      ntest++; if (en_ar !== 4'b1000) begin nfail++; $display("FAIL autorun_fe got %b exp 1000", en_ar); end
      ntest++; if (bus_ar.halted !== 1'b0) begin nfail++; $display("FAIL autorun_halted got %b exp 0", bus_ar.halted); end
   endtask
   task automatic test_run();
      logic [3:0] exp_en [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
      bus.run = 1'b1;
      #1;
      ntest++; if (en !== 4'b0000) begin nfail++; $display("FAIL run_pulse_en got %b exp 0000", en); end
      cyc();
      bus.run = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         ntest++; if (en !== exp_en[i]) begin nfail++; $display("FAIL run_en%0d got %b exp %b", i, en, exp_en[i]); end
         cyc();
      end
      ntest++; if (bus.instr_count !== 32'd1) begin nfail++; $display("FAIL run_icnt got %0d exp 1", bus.instr_count); end
      ntest++; if (en !== 4'b1000) begin nfail++; $display("FAIL run_refetch got %b exp 1000", en); end
   endtask
   task automatic test_stall();
      cyc();
      cyc();
      ntest++; if (en !== 4'b0010) begin nfail++; $display("FAIL stall_pre got %b exp 0010", en); end
      bus.stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         ntest++; if (en !== 4'b0000) begin nfail++; $display("FAIL stall_en%0d got %b exp 0000", i, en); end
         ntest++; if (bus.phase !== 2'd2) begin nfail++; $display("FAIL stall_phase%0d got %0d exp 2", i, bus.phase); end
         cyc();
      end
      bus.stall = 1'b0;
      #1;
      ntest++; if (en !== 4'b0010) begin nfail++; $display("FAIL stall_ex got %b exp 0010", en); end
      cyc();
      ntest++; if (en !== 4'b0001) begin nfail++; $display("FAIL stall_wb got %b exp 0001", en); end
      cyc();
      ntest++; if (bus.instr_count !== 32'd2) begin nfail++; $display("FAIL stall_icnt got %0d exp 2", bus.instr_count); end
   endtask
   task automatic test_halt();
      cyc();
      bus.halt_req = 1'b1;
      #1;
      ntest++; if (en !== 4'b0100) begin nfail++; $display("FAIL halt_dc got %b exp 0100", en); end
      cyc();
      bus.halt_req = 1'b0;
      #1;
      ntest++; if (en !== 4'b0010) begin nfail++; $display("FAIL halt_ex got %b exp 0010", en); end
      cyc();
      ntest++; if (en !== 4'b0001) begin nfail++; $display("FAIL halt_wb got %b exp 0001", en); end
      cyc();
      ntest++; if (bus.halted !== 1'b1) begin nfail++; $display("FAIL halt_done got %b exp 1", bus.halted); end
      ntest++; if (bus.phase !== 2'd0) begin nfail++; $display("FAIL halt_phase got %0d exp 0", bus.phase); end
      ntest++; if (en !== 4'b0000) begin nfail++; $display("FAIL halt_no_fe got %b exp 0000", en); end
      ntest++; if (bus.instr_count !== 32'd3) begin nfail++; $display("FAIL halt_icnt got %0d exp 3", bus.instr_count); end
      bus.stall = 1'b1;
      cyc();
      bus.stall = 1'b0;
      #1;
      ntest++; if (bus.halted !== 1'b1 || en !== 4'b0000) begin nfail++; $display("FAIL halt_stay got halted=%b en=%b exp 1 0000", bus.halted, en); end
   endtask
   task automatic test_step();
      logic [3:0] exp_en [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
      bus.step = 1'b1;
      cyc();
      bus.step = 1'b0;
      #1;
      ntest++; if (bus.halted !== 1'b0) begin nfail++; $display("FAIL step_active got %b exp 0", bus.halted); end
      for (int i = 0; i < 4; i++) begin
         ntest++; if (en !== exp_en[i]) begin nfail++; $display("FAIL step_en%0d got %b exp %b", i, en, exp_en[i]); end
         cyc();
      end
      ntest++; if (bus.halted !== 1'b1 || en !== 4'b0000) begin nfail++; $display("FAIL step_halt got halted=%b en=%b exp 1 0000", bus.halted, en); end
      ntest++; if (bus.instr_count !== 32'd4) begin nfail++; $display("FAIL step_icnt got %0d exp 4", bus.instr_count); end
   endtask
   task automatic test_back_to_back();
      logic [3:0] exp_en [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
      bus.run  = 1'b1;
      bus.step = 1'b1;
      cyc();
      bus.run  = 1'b0;
      bus.step = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         ntest++; if (en !== exp_en[i]) begin nfail++; $display("FAIL b2b_en%0d got %b exp %b", i, en, exp_en[i]); end
         cyc();
      end
      ntest++; if (en !== 4'b1000 || bus.halted !== 1'b0) begin nfail++; $display("FAIL b2b_continue got en=%b halted=%b exp 1000 0", en, bus.halted); end
      ntest++; if (bus.instr_count !== 32'd5) begin nfail++; $display("FAIL b2b_icnt got %0d exp 5", bus.instr_count); end
      cyc();
      cyc();
      cyc();
      bus.halt_req = 1'b1;
      #1;
      ntest++; if (en !== 4'b0001) begin nfail++; $display("FAIL wbhalt_wb got %b exp 0001", en); end
      cyc();
      bus.halt_req = 1'b0;
      #1;
      ntest++; if (bus.halted !== 1'b1 || en !== 4'b0000) begin nfail++; $display("FAIL wbhalt_done got halted=%b en=%b exp 1 0000", bus.halted, en); end
      ntest++; if (bus.instr_count !== 32'd6) begin nfail++; $display("FAIL wbhalt_icnt got %0d exp 6", bus.instr_count); end
   endtask
   task automatic test_stall_halt();
      bus.run = 1'b1;
      cyc();
      bus.run = 1'b0;
      cyc();
      bus.stall    = 1'b1;
      bus.halt_req = 1'b1;
      cyc();
      bus.stall    = 1'b0;
      bus.halt_req = 1'b0;
      #1;
      ntest++; if (en !== 4'b0100) begin nfail++; $display("FAIL sh_dc got %b exp 0100", en); end
      cyc();
      cyc();
      ntest++; if (en !== 4'b0001) begin nfail++; $display("FAIL sh_wb got %b exp 0001", en); end
      cyc();
      ntest++; if (bus.halted !== 1'b1 || en !== 4'b0000) begin nfail++; $display("FAIL sh_done got halted=%b en=%b exp 1 0000", bus.halted, en); end
      ntest++; if (bus.instr_count !== 32'd7) begin nfail++; $display("FAIL sh_icnt got %0d exp 7", bus.instr_count); end
   endtask
   task automatic test_reset_mid();
      bus.run = 1'b1;
      cyc();
      bus.run = 1'b0;
      cyc();
      cyc();
      ntest++; if (bus.phase !== 2'd2) begin nfail++; $display("FAIL rmid_pre got %0d exp 2", bus.phase); end
      rst = 1'b1;
      cyc();
      ntest++; if (bus.phase !== 2'd0 || bus.instr_count !== 32'd0) begin nfail++; $display("FAIL rmid_clear got phase=%0d icnt=%0d exp 0 0", bus.phase, bus.instr_count); end
      ntest++; if (bus.halted !== 1'b1) begin nfail++; $display("FAIL rmid_halted got %b exp 1", bus.halted); end
      rst = 1'b0;
      #1;
      ntest++; if (en_ar !== 4'b1000 || bus_ar.instr_count !== 32'd0) begin nfail++; $display("FAIL rmid_autorun got en=%b icnt=%0d exp 1000 0", en_ar, bus_ar.instr_count); end
      cyc();
      ntest++; if (en_ar !== 4'b0100) begin nfail++; $display("FAIL rmid_autorun_dc got %b exp 0100", en_ar); end
   endtask
   task automatic test_cycle_count();
      logic [31:0] exp_cc;
`ifdef STAGE_SEQ_CYCLE_COUNT_EN
      exp_cc = 32'd10;
`else
      exp_cc = 32'd0;
`endif
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      bus.run = 1'b1;
      cyc();
      bus.run = 1'b0;
      cyc();
      cyc();
      bus.stall = 1'b1;
      cyc();
      cyc();
      cyc();
      bus.stall = 1'b0;
      for (int i = 0; i < 5; i++) cyc();
      ntest++; if (bus.cycle_count !== exp_cc) begin nfail++; $display("FAIL ccnt got %0d exp %0d", bus.cycle_count, exp_cc); end
      ntest++; if (bus.instr_count !== 32'd1) begin nfail++; $display("FAIL ccnt_icnt got %0d exp 1", bus.instr_count); end
      ntest++; if (bus.phase !== 2'd3) begin nfail++; $display("FAIL ccnt_phase got %0d exp 3", bus.phase); end
   endtask
   initial begin
      bus.run         = 1'b0;
      bus.step        = 1'b0;
      bus.halt_req    = 1'b0;
      bus.stall       = 1'b0;
      bus_ar.run      = 1'b0;
      bus_ar.step     = 1'b0;
      bus_ar.halt_req = 1'b0;
      bus_ar.stall    = 1'b0;
      test_reset();
      test_run();
      test_stall();
      test_halt();
      test_step();
      test_back_to_back();
      test_stall_halt();
      test_reset_mid();
      test_cycle_count();
      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end
endmodule
